// File: rtl/audio_channel_init_seq.sv
// rtl/audio_channel_init_seq.sv - audio channel register initialisation sequencer
//
// Walks a fixed list of register writes that bring up NUM_CHANNELS audio
// channels: broadcast sample count, loop end and looping flag, an optional
// broadcast volume, one start address per channel, then a broadcast play.
// Optional feature macro: AUDIO_INIT_SEQ_VOLUME_EN adds parameter VOLUME and
// the broadcast volume write.
//
// Ports:
//   clk_25mhz       - clock, rising edge
//   rst             - synchronous active-low reset
//   start           - begin a sequence (accepted only in idle)
//   sample_count    - per-channel sample count / address stride, latched on start
//   base_addr       - start address of channel 0, latched on start
//   cfg_valid       - a register write is presented
//   cfg_ready       - the audio system accepts the presented write
//   channel_select  - one-hot channel mask, or all ones for broadcast writes
//   register_select - register index of the presented write
//   register_data   - data of the presented write
//   busy            - sequence in progress
//   done            - one-cycle completion pulse
module audio_channel_init_seq #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PLAY_VALUE   = 2
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
  ,
  parameter int VOLUME       = 255
`endif
) (
  input  logic                    clk_25mhz,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   sample_count,
  input  logic [DATA_WIDTH-1:0]   base_addr,
  output logic                    cfg_valid,
  input  logic                    cfg_ready,
  output logic [NUM_CHANNELS-1:0] channel_select,
  output logic [3:0]              register_select,
  output logic [DATA_WIDTH-1:0]   register_data,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [3:0] REG_STARTADDR   = 4'd1;
  localparam logic [3:0] REG_SAMPLECOUNT = 4'd2;
  localparam logic [3:0] REG_LOOPEND     = 4'd4;
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
  localparam logic [3:0] REG_VOLUME      = 4'd7;
`endif
  localparam logic [3:0] REG_ISLOOPING   = 4'd8;
  localparam logic [3:0] REG_ISPLAYING   = 4'd9;

  localparam logic [NUM_CHANNELS-1:0] ALL_CH   = '1;
  localparam logic [NUM_CHANNELS-1:0] CH0      = NUM_CHANNELS'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    BC_SAMPLECOUNT = 3'd1,
    BC_LOOPEND     = 3'd2,
    BC_LOOPING     = 3'd3,
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
    BC_VOLUME      = 3'd4,
`endif
    CH_ADDR        = 3'd5,
    BC_PLAY        = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic [NUM_CHANNELS-1:0] channel_select_q, channel_select_d;
  logic [3:0]              register_select_q, register_select_d;
  logic [DATA_WIDTH-1:0]   register_data_q, register_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   sc_q, sc_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;

  logic                    handshake;
  logic                    enter_ch;
  logic [DATA_WIDTH-1:0]   next_acc;
  logic [IDX_W-1:0]        next_ch_idx;

  assign handshake = cfg_valid_q & cfg_ready;

  // Outputs are registered: the next write is loaded on the accepting edge,
  // so a stalled write holds naturally and there is never a bubble.
  always_comb begin
    state_d           = state_q;
    cfg_valid_d       = cfg_valid_q;
    channel_select_d  = channel_select_q;
    register_select_d = register_select_q;
    register_data_d   = register_data_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    sc_d              = sc_q;
    acc_d             = acc_q;
    ch_idx_d          = ch_idx_q;
    enter_ch          = 1'b0;
    next_acc          = acc_q + sc_q;
    next_ch_idx       = ch_idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, in which start is still ignored.
        if (start && !done_q) begin
          state_d           = BC_SAMPLECOUNT;
          busy_d            = 1'b1;
          cfg_valid_d       = 1'b1;
          sc_d              = sample_count;
          acc_d             = base_addr;
          ch_idx_d          = '0;
          channel_select_d  = ALL_CH;
          register_select_d = REG_SAMPLECOUNT;
          register_data_d   = sample_count;
        end
      end
      BC_SAMPLECOUNT: begin
        if (handshake) begin
          state_d           = BC_LOOPEND;
          register_select_d = REG_LOOPEND;
          register_data_d   = sc_q;
        end
      end
      BC_LOOPEND: begin
        if (handshake) begin
          state_d           = BC_LOOPING;
          register_select_d = REG_ISLOOPING;
          register_data_d   = DATA_WIDTH'(1);
        end
      end
      BC_LOOPING: begin
        if (handshake) begin
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
          state_d           = BC_VOLUME;
          register_select_d = REG_VOLUME;
          register_data_d   = DATA_WIDTH'(VOLUME);
`else
          enter_ch          = 1'b1;
`endif
        end
      end
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
      BC_VOLUME: begin
        if (handshake) enter_ch = 1'b1;
      end
`endif
      CH_ADDR: begin
        if (handshake) begin
          // Accumulator steps by the stride once per accepted address write.
          acc_d    = next_acc;
          ch_idx_d = next_ch_idx;
          if (ch_idx_q == LAST_IDX) begin
            state_d           = BC_PLAY;
            channel_select_d  = ALL_CH;
            register_select_d = REG_ISPLAYING;
            register_data_d   = DATA_WIDTH'(PLAY_VALUE);
          end else begin
            channel_select_d  = CH0 << next_ch_idx;
            register_data_d   = next_acc;
          end
        end
      end
      BC_PLAY: begin
        if (handshake) begin
          state_d           = IDLE;
          cfg_valid_d       = 1'b0;
          busy_d            = 1'b0;
          done_d            = 1'b1;
          channel_select_d  = '0;
          register_select_d = '0;
          register_data_d   = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        cfg_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    // First per-channel address write: channel 0 at the base address.
    if (enter_ch) begin
      state_d           = CH_ADDR;
      channel_select_d  = CH0;
      register_select_d = REG_STARTADDR;
      register_data_d   = acc_q;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state_q           <= IDLE;
      cfg_valid_q       <= 1'b0;
      channel_select_q  <= '0;
      register_select_q <= '0;
      register_data_q   <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      sc_q              <= '0;
      acc_q             <= '0;
      ch_idx_q          <= '0;
    end else begin
      state_q           <= state_d;
      cfg_valid_q       <= cfg_valid_d;
      channel_select_q  <= channel_select_d;
      register_select_q <= register_select_d;
      register_data_q   <= register_data_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      sc_q              <= sc_d;
      acc_q             <= acc_d;
      ch_idx_q          <= ch_idx_d;
    end
  end

  assign cfg_valid       = cfg_valid_q;
  assign channel_select  = channel_select_q;
  assign register_select = register_select_q;
  assign register_data   = register_data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_audio_channel_init_seq.sv
// tb/tb_audio_channel_init_seq.sv - directed self-checking bench for audio_channel_init_seq
module tb_audio_channel_init_seq;

  localparam int N = 8;
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
  localparam int VOFF = 1;
`else
  localparam int VOFF = 0;
`endif
  localparam int NW = N + 4 + VOFF;

  int n_tests = 0;
  int n_fail  = 0;

  logic        clk_25mhz = 1'b0;
  logic        rst;
  always #20 clk_25mhz = ~clk_25mhz;

  // main instance: default parameters
  logic        start, cfg_ready, cfg_valid, busy, done;
  logic [31:0] sample_count, base_addr, register_data;
  logic [7:0]  channel_select;
  logic [3:0]  register_select;

  audio_channel_init_seq
`ifdef AUDIO_INIT_SEQ_VOLUME_EN
    #(.VOLUME(128))
`endif
    dut (
    .clk_25mhz(clk_25mhz), .rst(rst), .start(start),
    .sample_count(sample_count), .base_addr(base_addr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .channel_select(channel_select), .register_select(register_select),
    .register_data(register_data), .busy(busy), .done(done)
  );

  // 16-bit instance for address wrap
  logic        start16, ready16, valid16, busy16, done16;
  logic [15:0] sc16, base16, data16;
  logic [1:0]  chsel16;
  logic [3:0]  reg16;

  audio_channel_init_seq #(.NUM_CHANNELS(2), .DATA_WIDTH(16)) dut16 (
    .clk_25mhz(clk_25mhz), .rst(rst), .start(start16),
    .sample_count(sc16), .base_addr(base16),
    .cfg_valid(valid16), .cfg_ready(ready16),
    .channel_select(chsel16), .register_select(reg16),
    .register_data(data16), .busy(busy16), .done(done16)
  );

  // single-channel instance
  logic       start1, ready1, valid1, busy1, done1;
  logic [7:0] sc1, base1, data1;
  logic [0:0] chsel1;
  logic [3:0] reg1;

  audio_channel_init_seq #(.NUM_CHANNELS(1), .DATA_WIDTH(8)) dut1 (
    .clk_25mhz(clk_25mhz), .rst(rst), .start(start1),
    .sample_count(sc1), .base_addr(base1),
    .cfg_valid(valid1), .cfg_ready(ready1),
    .channel_select(chsel1), .register_select(reg1),
    .register_data(data1), .busy(busy1), .done(done1)
  );

  // expected write list for sample_count=27413, base_addr=0
  logic [7:0]  exp_mask [NW];
  logic [3:0]  exp_reg  [NW];
  logic [31:0] exp_data [NW];
  logic [7:0]  ch_mask  [N] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [31:0] ch_addr  [N] = '{32'd0, 32'd27413, 32'd54826, 32'd82239,
                                32'd109652, 32'd137065, 32'd164478, 32'd191891};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one sequence on the main instance. Optionally stalls write stall_at
  // for stall_len cycles and pokes start while busy and in the done cycle.
  task automatic run_seq(input int stall_at, input int stall_len, input bit poke,
                         output int nwr, output int nvalid, output int done_cyc);
    int stalled = 0;
    int held = 0;
    nwr = 0; nvalid = 0; done_cyc = 0;
    sample_count = 32'd27413; base_addr = 32'd0; cfg_ready = 1'b1;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        done_cyc = k;
        check("done_busy", busy, 0);
        check("done_valid", cfg_valid, 0);
        start = poke;
        break;
      end
      if (cfg_valid) begin
        nvalid++;
        if (nwr < NW) begin
          check($sformatf("w%0d_mask", nwr), channel_select, exp_mask[nwr]);
          check($sformatf("w%0d_reg", nwr), register_select, exp_reg[nwr]);
          check($sformatf("w%0d_data", nwr), register_data, exp_data[nwr]);
        end
        if (nwr == stall_at) held++;
        cfg_ready = !(nwr == stall_at && stalled < stall_len);
        if (!cfg_ready) stalled++;
        else nwr++;
      end else begin
        check($sformatf("bubble_c%0d", k), cfg_valid, 1);
      end
      start = poke && (k == 5);
      @(negedge clk_25mhz);
    end
    cfg_ready = 1'b1;
    if (stall_at >= 0) check("stall_hold", held, stall_len + 1);
  endtask

  int nwr, nvalid, dcyc, cnt;

  initial begin
    exp_mask[0] = 8'hFF; exp_reg[0] = 4'd2; exp_data[0] = 32'd27413;
    exp_mask[1] = 8'hFF; exp_reg[1] = 4'd4; exp_data[1] = 32'd27413;
    exp_mask[2] = 8'hFF; exp_reg[2] = 4'd8; exp_data[2] = 32'd1;
    if (VOFF == 1) begin
      exp_mask[3] = 8'hFF; exp_reg[3] = 4'd7; exp_data[3] = 32'd128;
    end
    for (int i = 0; i < N; i++) begin
      exp_mask[3+VOFF+i] = ch_mask[i]; exp_reg[3+VOFF+i] = 4'd1; exp_data[3+VOFF+i] = ch_addr[i];
    end
    exp_mask[NW-1] = 8'hFF; exp_reg[NW-1] = 4'd9; exp_data[NW-1] = 32'd2;

    rst = 1'b0; start = 1'b1; cfg_ready = 1'b1; sample_count = 32'd5; base_addr = 32'd7;
    start16 = 1'b0; ready16 = 1'b1; sc16 = 16'h2000; base16 = 16'hF000;
    start1 = 1'b0; ready1 = 1'b1; sc1 = 8'd10; base1 = 8'd3;
    repeat (3) @(negedge clk_25mhz);
    check("rst_valid", cfg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chsel", channel_select, 0);
    check("rst_reg", register_select, 0);
    check("rst_data", register_data, 0);
    start = 1'b0; rst = 1'b1;
    @(negedge clk_25mhz);

    // baseline back-to-back sequence
    run_seq(-1, 0, 1'b0, nwr, nvalid, dcyc);
    check("base_nwr", nwr, NW);
    check("base_nvalid", nvalid, NW);
    check("base_done_cyc", dcyc, NW + 1);
    @(negedge clk_25mhz);
    check("base_done_pulse", done, 0);
    @(negedge clk_25mhz);

    // backpressure on the 2nd write for 3 cycles
    run_seq(1, 3, 1'b0, nwr, nvalid, dcyc);
    check("stall_nwr", nwr, NW);
    check("stall_nvalid", nvalid, NW + 3);
    check("stall_done_cyc", dcyc, NW + 4);
    @(negedge clk_25mhz);
    @(negedge clk_25mhz);

    // start while busy and in the done cycle is ignored; one cycle later is accepted
    run_seq(-1, 0, 1'b1, nwr, nvalid, dcyc);
    check("poke_nwr", nwr, NW);
    check("poke_done_cyc", dcyc, NW + 1);
    @(negedge clk_25mhz);
    check("poke_ignored_valid", cfg_valid, 0);
    check("poke_ignored_busy", busy, 0);
    run_seq(-1, 0, 1'b0, nwr, nvalid, dcyc);
    check("restart_nwr", nwr, NW);
    check("restart_done_cyc", dcyc, NW + 1);
    @(negedge clk_25mhz);

    // reset during the 6th write abandons the sequence
    sample_count = 32'd27413; base_addr = 32'd0; cfg_ready = 1'b1;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    for (int k = 1; k < 6; k++) @(negedge clk_25mhz);
    check("w6_reg", register_select, exp_reg[5]);
    check("w6_data", register_data, exp_data[5]);
    rst = 1'b0;
    @(negedge clk_25mhz);
    check("midrst_valid", cfg_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_chsel", channel_select, 0);
    rst = 1'b1;
    @(negedge clk_25mhz);
    check("midrst_stays_idle", cfg_valid, 0);
    run_seq(-1, 0, 1'b0, nwr, nvalid, dcyc);
    check("after_rst_nwr", nwr, NW);
    check("after_rst_done_cyc", dcyc, NW + 1);
    @(negedge clk_25mhz);

    // 16-bit address wrap: 0xF000 + 0x2000 -> 0x1000
    start16 = 1'b1;
    @(negedge clk_25mhz);
    start16 = 1'b0;
    repeat (3 + VOFF) @(negedge clk_25mhz);
    check("w16_ch0_mask", chsel16, 2'b01);
    check("w16_ch0_reg", reg16, 4'd1);
    check("w16_ch0_data", data16, 16'hF000);
    @(negedge clk_25mhz);
    check("w16_ch1_mask", chsel16, 2'b10);
    check("w16_ch1_data", data16, 16'h1000);
    cnt = 0;
    while (!done16 && cnt < 40) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    check("w16_done_seen", done16, 1);
    check("w16_done_cyc", cnt, 2);

    // single channel: exactly one address write
    start1 = 1'b1;
    @(negedge clk_25mhz);
    start1 = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done1) break;
      if (valid1) cnt++;
      if (valid1 && k == 4 + VOFF) begin
        check("n1_addr_reg", reg1, 4'd1);
        check("n1_addr_mask", chsel1, 1'b1);
        check("n1_addr_data", data1, 8'd3);
      end
      if (valid1 && k == 5 + VOFF) check("n1_play_reg", reg1, 4'd9);
      @(negedge clk_25mhz);
    end
    check("n1_done_seen", done1, 1);
    check("n1_nwrites", cnt, 5 + VOFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
